// File: rtl/sisc_pkg.sv
// Shared types and constants for the SISC data-memory responder.
package sisc_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

   localparam int SISC_DATA_W = 32;
   localparam int SISC_ADDR_W = 8;
   localparam int MEM_WORDS   = 192;
   localparam int CNT_W       = 4;
endpackage

// File: rtl/sisc_mem_array.sv
// Single-port word RAM: synchronous write, registered read with a clear input.
module sisc_mem_array #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_f,
   input  logic              we,
   input  logic              re,
   input  logic              rclr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Contents are deliberately left unreset.
   always_ff @(posedge clk)
      if (we) mem[addr] <= wdata;

   always_ff @(posedge clk or negedge rst_f)
      if (!rst_f)    rdata <= '0;
      else if (rclr) rdata <= '0;
      else if (re)   rdata <= mem[addr];
endmodule

// File: rtl/sisc_mem_resp.sv
// Four-phase req/ack data-memory responder with WAIT_CYC wait states.
// Define SISC_MEM_BOUNDS_EN to flag and suppress accesses at or above MEM_WORDS.
module sisc_mem_resp
   import sisc_pkg::*;
#(
   parameter int DATA_W   = SISC_DATA_W,
   parameter int ADDR_W   = SISC_ADDR_W,
   parameter int WAIT_CYC = 2
) (
   input  logic              clk,
   input  logic              rst_f,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              ack,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic              busy
);
   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              lat, mem_we, mem_re, rd_clr, in_range;

`ifdef SISC_MEM_BOUNDS_EN
   assign in_range = int'(addr_q) < MEM_WORDS;
`else
   assign in_range = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_f)
      if (!rst_f) begin
         state <= IDLE;
         cnt   <= '0;
         ack   <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         ack   <= state_nxt == ACK;
         busy  <= state_nxt != IDLE;
      end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      lat       = 1'b0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      rd_clr    = 1'b0;
      case (state)
         IDLE:
            if (req) begin
               lat       = 1'b1;
               cnt_nxt   = CNT_W'(WAIT_CYC);
               state_nxt = WAIT;
            end
         WAIT:
            // The access commits even if req has already dropped.
            if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
            else begin
               state_nxt = ACK;
               mem_we    = we_q & in_range;
               mem_re    = ~we_q & in_range;
               rd_clr    = ~we_q & ~in_range;
            end
         ACK:
            if (!req) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_f)
      if (!rst_f) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (lat) begin
         we_q    <= we;
         addr_q  <= addr;
         wdata_q <= wdata;
      end

`ifdef SISC_MEM_BOUNDS_EN
   always_ff @(posedge clk or negedge rst_f)
      if (!rst_f)                              err <= 1'b0;
      else if (lat)                            err <= 1'b0;
      else if (state == WAIT && cnt == '0)     err <= ~in_range;
`else
   assign err = 1'b0;
`endif

   sisc_mem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_array (
      .clk   (clk),
      .rst_f (rst_f),
      .we    (mem_we),
      .re    (mem_re),
      .rclr  (rd_clr),
      .addr  (addr_q),
      .wdata (wdata_q),
      .rdata (rdata)
   );
endmodule

// File: tb/tb_sisc_mem_resp.sv
// Self-checking bench: WAIT_CYC=2 and WAIT_CYC=0 instances against a word-array model.
module tb_sisc_mem_resp;
   localparam int W2 = 2;

   logic clk = 1'b0;
   logic rst_f = 1'b0;
   always #5 clk = ~clk;

   logic req = 0, we = 0, ack, err, busy;
   logic [7:0] addr = 0;
   logic [31:0] wdata = 0, rdata;
   logic req0 = 0, we0 = 0, ack0, err0, busy0;
   logic [7:0] addr0 = 0;
   logic [31:0] wdata0 = 0, rdata0;

   sisc_mem_resp #(.DATA_W(32), .ADDR_W(8), .WAIT_CYC(W2)) dut (
      .clk(clk), .rst_f(rst_f), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ack(ack), .rdata(rdata), .err(err), .busy(busy));
   sisc_mem_resp #(.DATA_W(32), .ADDR_W(8), .WAIT_CYC(0)) dut0 (
      .clk(clk), .rst_f(rst_f), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
      .ack(ack0), .rdata(rdata0), .err(err0), .busy(busy0));

   int n_chk = 0, n_fail = 0;
   logic [31:0] m2 [256];
   bit          k2 [256];
   logic [31:0] m0 [256];

   function automatic bit oob(input logic [7:0] a);
`ifdef SISC_MEM_BOUNDS_EN
      return a >= 8'd192;
`else
      return 1'b0;
`endif
   endfunction

   // One complete handshake on the WAIT_CYC=2 instance; inputs change right after an edge.
   task automatic acc2(input logic w, input logic [7:0] a, input logic [31:0] d);
      int n;
      bit o;
      logic [31:0] exp;
      o = oob(a);
      req = 1; we = w; addr = a; wdata = d;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
         if (n == 1) begin
            n_chk++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL acc2_busy addr=%h got=%b exp=1", a, busy); end
         end
      end while (ack !== 1'b1 && n < 40);
      n_chk++;
      if (n !== W2 + 2) begin n_fail++; $display("FAIL acc2_latency addr=%h got=%0d exp=%0d", a, n, W2 + 2); end
      n_chk++;
      if (err !== o) begin n_fail++; $display("FAIL acc2_err addr=%h got=%b exp=%b", a, err, o); end
      if (!w && (o || k2[a])) begin
         exp = o ? 32'h0 : m2[a];
         n_chk++;
         if (rdata !== exp) begin n_fail++; $display("FAIL acc2_rdata addr=%h got=%h exp=%h", a, rdata, exp); end
      end
      if (w && !o) begin m2[a] = d; k2[a] = 1'b1; end
      req = 0;
      @(posedge clk); #1;
      n_chk++;
      if ({ack, busy} !== 2'b00) begin n_fail++; $display("FAIL acc2_release addr=%h got=%b%b exp=00", a, ack, busy); end
   endtask

   task automatic acc0(input logic w, input logic [7:0] a, input logic [31:0] d, input int hold);
      int n;
      req0 = 1; we0 = w; addr0 = a; wdata0 = d;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (ack0 !== 1'b1 && n < 40);
      n_chk++;
      if (n !== 2) begin n_fail++; $display("FAIL w0_latency addr=%h got=%0d exp=2", a, n); end
      if (!w) begin
         n_chk++;
         if (rdata0 !== m0[a]) begin n_fail++; $display("FAIL w0_rdata addr=%h got=%h exp=%h", a, rdata0, m0[a]); end
      end else m0[a] = d;
      // A held request must not start another access, even with new write inputs.
      we0 = 1; wdata0 = ~d;
      for (int i = 1; i < hold; i++) begin
         @(posedge clk); #1;
         n_chk++;
         if (ack0 !== 1'b1) begin n_fail++; $display("FAIL w0_hold cycle=%0d got=%b exp=1", i, ack0); end
      end
      req0 = 0;
      @(posedge clk); #1;
      n_chk++;
      if (ack0 !== 1'b0) begin n_fail++; $display("FAIL w0_release got=%b exp=0", ack0); end
   endtask

   task automatic test_reset();
      int n;
      req = 1; we = 1; addr = 8'h20; wdata = 32'h1234_5678;
      repeat (3) @(posedge clk);
      #1;
      n_chk++;
      if ({ack, busy, err} !== 3'b000 || rdata !== 32'h0) begin
         n_fail++; $display("FAIL reset_outputs got ack=%b busy=%b err=%b rdata=%h exp 0", ack, busy, err, rdata);
      end
      n_chk++;
      if ({ack0, busy0, err0} !== 3'b000 || rdata0 !== 32'h0) begin
         n_fail++; $display("FAIL reset_outputs0 got ack=%b busy=%b err=%b rdata=%h exp 0", ack0, busy0, err0, rdata0);
      end
      @(negedge clk); rst_f = 1;
      @(posedge clk); #1;
      n_chk++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_first_sample got=%b exp=1", busy); end
      n = 1;
      while (ack !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
      n_chk++;
      if (n !== W2 + 2) begin n_fail++; $display("FAIL reset_latency got=%0d exp=%0d", n, W2 + 2); end
      m2[8'h20] = 32'h1234_5678; k2[8'h20] = 1'b1;
      req = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_write_read();
      acc2(1, 8'h10, 32'hDEAD_BEEF);
      acc2(0, 8'h10, 32'h0);
      acc2(0, 8'h20, 32'h0);
   endtask

   task automatic test_wait0();
      acc0(1, 8'h05, 32'hA5A5_0001, 1);
      acc0(0, 8'h05, 32'h0, 5);
      acc0(0, 8'h05, 32'h0, 1);
   endtask

   task automatic test_mid_access();
      int n;
      acc2(1, 8'h41, 32'h0000_4141);
      req = 1; we = 1; addr = 8'h40; wdata = 32'h0000_4040;
      @(posedge clk); #1;
      addr = 8'h41; wdata = 32'hFFFF_FFFF; we = 0;
      n = 1;
      while (ack !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
      n_chk++;
      if (n !== W2 + 2) begin n_fail++; $display("FAIL mid_latency got=%0d exp=%0d", n, W2 + 2); end
      m2[8'h40] = 32'h0000_4040; k2[8'h40] = 1'b1;
      req = 0;
      @(posedge clk); #1;
      acc2(0, 8'h40, 32'h0);
      acc2(0, 8'h41, 32'h0);
      // Reset during WAIT of a write must leave the old contents.
      req = 1; we = 1; addr = 8'h40; wdata = 32'h0BAD_0BAD;
      @(posedge clk); #1;
      rst_f = 0; req = 0;
      #1;
      n_chk++;
      if ({ack, busy} !== 2'b00) begin n_fail++; $display("FAIL mid_reset_async got=%b%b exp=00", ack, busy); end
      repeat (2) @(posedge clk);
      @(negedge clk); rst_f = 1;
      repeat (4) @(posedge clk);
      #1;
      acc2(0, 8'h40, 32'h0);
   endtask

   task automatic test_early_drop();
      int first, cnt_ack;
      req = 1; we = 1; addr = 8'h50; wdata = 32'h5050_CAFE;
      @(posedge clk); #1;
      req = 0;
      first = 0; cnt_ack = 0;
      for (int i = 2; i <= 12; i++) begin
         @(posedge clk); #1;
         if (ack === 1'b1) begin
            cnt_ack++;
            if (first == 0) first = i;
         end
      end
      n_chk++;
      if (first !== W2 + 2) begin n_fail++; $display("FAIL early_ack_edge got=%0d exp=%0d", first, W2 + 2); end
      n_chk++;
      if (cnt_ack !== 1) begin n_fail++; $display("FAIL early_ack_width got=%0d exp=1", cnt_ack); end
      m2[8'h50] = 32'h5050_CAFE; k2[8'h50] = 1'b1;
      acc2(0, 8'h50, 32'h0);
   endtask

   task automatic test_bounds();
      acc2(1, 8'hBF, 32'h0000_00BF);
      acc2(1, 8'hC8, 32'h0000_0005);
      acc2(0, 8'hC8, 32'h0);
      acc2(0, 8'hBF, 32'h0);
   endtask

   task automatic test_back_to_back();
      logic w;
      logic [7:0] a;
      for (int i = 0; i < 30; i++) begin
         w = 1'($urandom_range(0, 1));
         a = ($urandom_range(0, 1) != 0) ? 8'hC0 : 8'h00;
         a = a | 8'($urandom_range(0, 15));
         acc2(w, a, $urandom);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_write_read();
      test_wait0();
      test_mid_access();
      test_early_drop();
      test_bounds();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/sisc_mem_resp.md
# sisc_mem_resp

Data-memory responder for the SISC processor's `mem` stage. The controller and datapath act as initiator and raise a request; this block acts as responder. It latches the address, write flag and write data, inserts a configurable number of wait states, then performs the read or write on an internal word array. It completes a four-phase req/ack handshake so the controller FSM can hold in `mem` until the access is done.

## Interface
Parameters:
- `DATA_W`, 32: word width; matches the SISC register file.
- `ADDR_W`, 8: word-address width; array depth is 2**ADDR_W.
- `WAIT_CYC`, 2: wait states inserted before `ack`; legal range 0–15.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_f` in 1: asynchronous, active-low reset.
- `req` in 1: access request from the controller; four-phase.
- `we` in 1: 1 = write, 0 = read; sampled with `req`.
- `addr` in ADDR_W: word address; sampled with `req`.
- `wdata` in DATA_W: store data; sampled with `req`.
- `ack` out 1: access complete; held until `req` falls.
- `rdata` out DATA_W: read data; valid while `ack`=1 after a read.
- `err` out 1: address out of range (see Configuration); valid while `ack`=1.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States:
  - IDLE: `req`=1 → latch `we`/`addr`/`wdata`, load `cnt`=WAIT_CYC, go to WAIT.
  - WAIT: `cnt`≠0 → decrement `cnt`. `cnt`=0 → perform the access, go to ACK.
  - ACK: `ack`=1. `req`=0 → go to IDLE; otherwise stay in ACK.
- Access at the WAIT→ACK edge:
  - Write: `mem[addr_q]` ← `wdata_q`; `rdata` unchanged.
  - Read: `rdata` ← `mem[addr_q]`, registered.
- `req` is ignored outside IDLE. `addr`/`we`/`wdata` changing after sampling has no effect.
- `req` still high in ACK: no new access, `ack` stays high. A new access requires `req` to fall, then rise again.
- `req` falling in WAIT (protocol violation): the access still completes. ACK is then left on the next edge because `req`=0. `ack` is high for exactly 1 cycle.
- Read-after-write to the same address returns the new data.
- Array contents are not reset. Reads before any write return X in simulation.

## Timing
- Reset (async, `rst_f`=0): state=IDLE, `ack`=0, `rdata`=0, `err`=0, `busy`=0, `cnt`=0.
- Reset mid-access aborts the access. A write not yet committed is not performed.
- `req` seen high at edge T0 → `busy`=1 after T0 → `ack`=1 after edge T0+WAIT_CYC+1.
- WAIT_CYC=0: `ack` rises one cycle after `req` is sampled.
- `ack` falls on the first edge that samples `req`=0 in ACK.
- Back-to-back minimum spacing: req-rise to req-rise = WAIT_CYC+3 cycles.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- `SISC_MEM_BOUNDS_EN` defined:
  - Extra parameter check: addresses ≥ `MEM_WORDS` (package constant, default 192) are out of range.
  - Out-of-range write is suppressed. Out-of-range read returns `rdata`=0.
  - `err`=1 for the ACK phase of that access; the handshake is otherwise unchanged.
- Undefined: the full 2**ADDR_W range is valid, `err` is tied to 0, and there is no compare logic.

## Structure
- `sisc_pkg` holds:
  - the state enum (IDLE, WAIT, ACK);
  - the `DATA_W`/`ADDR_W` defaults;
  - `MEM_WORDS`;
  - the wait-count width constant (4).
- Sub-module `sisc_mem_array`: synchronous single-port RAM with write enable and registered read. The FSM, sampling registers and bounds logic stay in `sisc_mem_resp`.

## Test plan
- Reset: `rst_f`=0 with `req`=1 → `ack`=0, `rdata`=0, `busy`=0. After release, `req` is sampled on the first edge.
- Write then read, WAIT_CYC=2: write 0xDEADBEEF to addr 0x10, then read 0x10 → `ack` at T0+3 both times, `rdata`=0xDEADBEEF.
- WAIT_CYC=0: read → `ack` one cycle after `req`. Hold `req` high 5 cycles → `ack` high 5 cycles, exactly one access.
- Mid-access: change `addr` and `wdata` during WAIT → the original address and data are committed. Assert `rst_f`=0 during WAIT of a write → the location keeps its old value.
- Bounds (`SISC_MEM_BOUNDS_EN`): write 0x5 to addr 0xC8 → `err`=1, no write. Read 0xC8 → `rdata`=0, `err`=1. Read addr 0xBF → `err`=0.
- Early `req` drop in WAIT → access completes and `ack` pulses for 1 cycle.
